// File: rtl/fetch_stall_ctrl_if.sv
// Stall/branch handshake between the hazard unit, instruction memory and the fetch stage.
// The fetch controller sits on the slave modport.
interface fetch_stall_ctrl_if;
  logic        hold_pc;
  logic        hold_if_id;
  logic        mux_sel;
  logic [31:0] imem_instr;
  logic        br_resolve;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic        stall_err;
  logic        br_err;

  modport master (
    output hold_pc, hold_if_id, mux_sel, imem_instr, br_resolve, br_taken, br_target,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, id_ex_bubble, stall_err, br_err
  );

  modport slave (
    input  hold_pc, hold_if_id, mux_sel, imem_instr, br_resolve, br_taken, br_target,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, id_ex_bubble, stall_err, br_err
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch stage: PC + IF/ID register under hazard-unit holds, with beq fetch squash
// and redirect on branch resolution.
module fetch_stall_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0,
  parameter int          BR_TIMEOUT = 4,
  parameter int          MAX_STALL  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_stall_ctrl_if.slave bus
);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int BW = $clog2(BR_TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(MAX_STALL);
  localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);
  localparam logic [BW-1:0] BR_LAST    = BW'(BR_TIMEOUT - 1);

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   if_id_instr;
  logic [31:0]   if_id_pc4;
  logic          if_id_valid;
  logic          stall_err;
  logic          br_err;
  logic [SW-1:0] stall_cnt;
  logic [BW-1:0] br_cnt;
  logic [31:0]   pc_plus4;
  logic          hold;
  logic          is_beq;
  logic          bubble;

  assign pc_plus4 = pc + 32'd4;
  assign hold     = bus.hold_pc | bus.hold_if_id;
  assign is_beq   = if_id_valid && (if_id_instr[31:26] == 6'b000100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= PC_RESET;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      stall_cnt   <= '0;
      br_cnt      <= '0;
      stall_err   <= 1'b0;
      br_err      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            // Each register obeys only its own hold; holds outrank beq detection.
            if (!bus.hold_pc) pc <= pc_plus4;
            if (!bus.hold_if_id) begin
              if_id_instr <= bus.imem_instr;
              if_id_pc4   <= pc_plus4;
              if_id_valid <= 1'b1;
            end
            if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_LAST) stall_err <= 1'b1;
          end else if (is_beq) begin
            // beq moves on to ID; the word fetched behind it is dropped.
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            br_cnt      <= '0;
            stall_cnt   <= '0;
            state       <= BR_WAIT;
          end else begin
            pc          <= pc_plus4;
            if_id_instr <= bus.imem_instr;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            stall_cnt   <= '0;
          end
        end
        BR_WAIT: begin
          br_cnt <= br_cnt + 1'b1;
          if (bus.br_resolve) begin
            if (bus.br_taken) pc <= bus.br_target;
            state <= RUN;
          end else if (br_cnt == BR_LAST) begin
            br_err <= 1'b1;
            state  <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    bubble = 1'b0;
    if (!rst_n)                bubble = 1'b0;
    else if (state == BR_WAIT) bubble = 1'b1;
    else if (hold)             bubble = bus.mux_sel;
  end

  assign bus.imem_addr    = pc;
  assign bus.if_id_instr  = if_id_instr;
  assign bus.if_id_pc4    = if_id_pc4;
  assign bus.if_id_valid  = if_id_valid;
  assign bus.id_ex_bubble = bubble;
  assign bus.stall_err    = stall_err;
  assign bus.br_err       = br_err;
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed scenarios plus randomized holds/branches against a behavioural fetch model.
module tb_fetch_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  fetch_stall_ctrl_if bus();
  fetch_stall_ctrl #(.PC_RESET(32'h0), .BR_TIMEOUT(4), .MAX_STALL(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign bus.imem_instr = mem[bus.imem_addr[7:2]];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_wait, m_serr, m_berr;
  int          m_wait_cycles, m_hold_run;
  logic        last_bubble;

  localparam logic [31:0] BEQ = 32'h1000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
    m_wait = 0; m_wait_cycles = 0; m_hold_run = 0; m_serr = 0; m_berr = 0;
  endtask

  function automatic logic model_bubble();
    if (!rst_n) return 1'b0;
    if (m_wait) return 1'b1;
    if (bus.hold_pc || bus.hold_if_id) return bus.mux_sel;
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic [31:0] fetched, next_pc;
    fetched = mem[m_pc[7:2]];
    next_pc = m_pc + 32'd4;
    if (m_wait) begin
      m_wait_cycles++;
      if (bus.br_resolve) begin
        if (bus.br_taken) m_pc = bus.br_target;
        m_wait = 0;
      end else if (m_wait_cycles == 4) begin
        m_berr = 1; m_wait = 0;
      end
    end else if (bus.hold_pc || bus.hold_if_id) begin
      if (!bus.hold_if_id) begin m_instr = fetched; m_pc4 = next_pc; m_valid = 1; end
      if (!bus.hold_pc) m_pc = next_pc;
      m_hold_run = (m_hold_run + 1 > 15) ? 15 : m_hold_run + 1;
      if (m_hold_run == 15) m_serr = 1;
    end else if (m_valid && m_instr[31:26] == 6'b000100) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      m_wait = 1; m_wait_cycles = 0; m_hold_run = 0;
    end else begin
      m_instr = fetched; m_pc4 = next_pc; m_valid = 1; m_pc = next_pc; m_hold_run = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"},   bus.imem_addr,   m_pc);
    chk({tag, ".if_id_instr"}, bus.if_id_instr, m_instr);
    chk({tag, ".if_id_pc4"},   bus.if_id_pc4,   m_pc4);
    chk({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(m_valid));
    chk({tag, ".stall_err"},   32'(bus.stall_err),   32'(m_serr));
    chk({tag, ".br_err"},      32'(bus.br_err),      32'(m_berr));
  endtask

  // One clock: check the combinational bubble mid-cycle, then registers just after the edge.
  task automatic step();
    #2;
    last_bubble = bus.id_ex_bubble;
    chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(model_bubble()));
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    chk("rst_bubble", 32'(bus.id_ex_bubble), 32'h0);
    @(posedge clk);
    #1 check_all("rst_held");
    rst_n = 1'b1;
  endtask

  task automatic clr_in();
    bus.hold_pc = 0; bus.hold_if_id = 0; bus.mux_sel = 0;
    bus.br_resolve = 0; bus.br_taken = 0; bus.br_target = 32'h0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int burst;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {6'b001000, 26'(i * 7 + 1)};
    clr_in();
    rst_n = 1'b0;
    model_reset();
    #7;
    check_all("por");
    chk("por_pc", bus.imem_addr, 32'h0);
    rst_n = 1'b1;

    // Free run to 0x20, then asynchronous reset without a clock edge
    steps(8);
    chk("t1_pc_before", bus.imem_addr, 32'h20);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("t1_pc_async", bus.imem_addr, 32'h0);
    chk("t1_valid_async", 32'(bus.if_id_valid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch
    chk("t2_pc0", bus.imem_addr, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_pc", bus.imem_addr, 32'(4 * i));
      chk("t2_pc4", bus.if_id_pc4, 32'(4 * i));
    end

    // One-cycle full hold at pc=8
    reset_pulse();
    steps(2);
    bus.hold_pc = 1; bus.hold_if_id = 1; bus.mux_sel = 1;
    step();
    chk("t3_bubble", 32'(last_bubble), 32'h1);
    chk("t3_pc", bus.imem_addr, 32'h8);
    chk("t3_pc4", bus.if_id_pc4, 32'h8);
    clr_in();
    step();
    chk("t3_bubble_off", 32'(last_bubble), 32'h0);
    chk("t3_pc_next", bus.imem_addr, 32'hC);

    // beq at 0x10, taken to 0x40 two cycles later
    mem[4] = BEQ | 32'h0000_0003;
    reset_pulse();
    steps(5);
    chk("t4_beq_in_ifid", bus.if_id_instr, BEQ | 32'h3);
    chk("t4_pc14", bus.imem_addr, 32'h14);
    step();
    chk("t4_squash_instr", bus.if_id_instr, 32'h0);
    chk("t4_squash_valid", 32'(bus.if_id_valid), 32'h0);
    chk("t4_pc_held", bus.imem_addr, 32'h14);
    step();
    chk("t4_wait_bubble", 32'(last_bubble), 32'h1);
    bus.br_resolve = 1; bus.br_taken = 1; bus.br_target = 32'h40;
    step();
    chk("t4_redirect", bus.imem_addr, 32'h40);
    clr_in();
    step();
    chk("t4_after_pc", bus.imem_addr, 32'h44);
    chk("t4_after_pc4", bus.if_id_pc4, 32'h44);

    // Not taken, with a hold pulse ignored during BR_WAIT
    reset_pulse();
    steps(6);
    bus.hold_pc = 1; bus.hold_if_id = 1; bus.mux_sel = 1;
    step();
    chk("t5_hold_ignored_pc", bus.imem_addr, 32'h14);
    clr_in();
    bus.br_resolve = 1; bus.br_taken = 0; bus.br_target = 32'h80;
    step();
    chk("t5_nt_pc", bus.imem_addr, 32'h14);
    clr_in();
    step();
    chk("t5_resume_pc", bus.imem_addr, 32'h18);
    chk("t5_resume_pc4", bus.if_id_pc4, 32'h18);
    chk("t5_resume_valid", 32'(bus.if_id_valid), 32'h1);

    // Long hold -> stall_err; unresolved branch -> br_err
    reset_pulse();
    bus.hold_pc = 1; bus.hold_if_id = 1;
    steps(14);
    chk("t6_serr_early", 32'(bus.stall_err), 32'h0);
    steps(2);
    chk("t6_serr", 32'(bus.stall_err), 32'h1);
    clr_in();
    steps(6);
    chk("t6_serr_sticky", 32'(bus.stall_err), 32'h1);
    steps(3);
    chk("t6_berr_early", 32'(bus.br_err), 32'h0);
    step();
    chk("t6_berr", 32'(bus.br_err), 32'h1);
    chk("t6_pc_unchanged", bus.imem_addr, 32'h14);
    step();
    chk("t6_run_again", bus.imem_addr, 32'h18);

    // PC wrap from 0xFFFFFFFC
    reset_pulse();
    chk("t7_errs_cleared", 32'({bus.stall_err, bus.br_err}), 32'h0);
    steps(6);
    bus.br_resolve = 1; bus.br_taken = 1; bus.br_target = 32'hFFFF_FFFC;
    step();
    chk("t7_top", bus.imem_addr, 32'hFFFF_FFFC);
    clr_in();
    step();
    chk("t7_wrap_pc", bus.imem_addr, 32'h0);
    chk("t7_wrap_pc4", bus.if_id_pc4, 32'h0);

    // Randomized holds, branches and resets
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(5, 0) == 0) mem[i][31:26] = 6'b000100;
    end
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst == 0 && $urandom_range(199, 0) == 0) burst = $urandom_range(20, 10);
      if (burst > 0) begin
        burst--;
        bus.hold_pc = 1; bus.hold_if_id = 1;
      end else begin
        bus.hold_pc    = ($urandom_range(5, 0) == 0);
        bus.hold_if_id = ($urandom_range(5, 0) == 0);
      end
      bus.mux_sel    = $urandom_range(1, 0) == 1;
      bus.br_resolve = ($urandom_range(3, 0) == 0);
      bus.br_taken   = $urandom_range(1, 0) == 1;
      bus.br_target  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(299, 0) == 0) reset_pulse();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
